// File: rtl/ro_buffer.sv
// ro_buffer: in-order reorder buffer sitting at the consumer end of the
// reservation-station and load/store result buses. Entries are allocated at
// the tail by the issuer, become ready when their tag appears on a result bus,
// and retire one per cycle from the head. A branch whose resolved next pc
// differs from its prediction flushes every entry and pulses the rob bus reset.
// Entry ID equals bus tag; ID 0 means "no entry" everywhere.
module ro_buffer #(
  parameter int RO_BUFFER_SIZE = 16,
  parameter int ID_WIDTH       = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                alloc_valid_from_issuer,
  input  logic                is_branch_from_issuer,
  input  logic                is_store_from_issuer,
  input  logic [4:0]          rd_from_issuer,
  input  logic [31:0]         pred_pc_from_issuer,
  output logic [ID_WIDTH-1:0] tail_id_to_issuer,
  input  logic [ID_WIDTH-1:0] query_id_from_issuer,
  output logic                query_ready_to_issuer,
  output logic [31:0]         query_value_to_issuer,
  input  logic [ID_WIDTH-1:0] dest_from_rss_bus,
  input  logic [31:0]         value_from_rss_bus,
  input  logic [31:0]         next_pc_from_rss_bus,
  input  logic [ID_WIDTH-1:0] dest_from_lsb_bus,
  input  logic [31:0]         value_from_lsb_bus,
  output logic [4:0]          rd_to_reg_file,
  output logic [ID_WIDTH-1:0] dest_to_reg_file,
  output logic [31:0]         value_to_reg_file,
  output logic [ID_WIDTH-1:0] store_id_to_lsb,
  output logic                reset_to_rob_bus,
  output logic [31:0]         target_pc_to_fetcher,
  output logic                is_ro_buffer_full
);

  localparam logic [ID_WIDTH-1:0] LP_N    = ID_WIDTH'(RO_BUFFER_SIZE);
  localparam logic [ID_WIDTH-1:0] LP_N_M1 = ID_WIDTH'(RO_BUFFER_SIZE - 1);
  localparam logic [ID_WIDTH-1:0] LP_ONE  = ID_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0] LP_ZERO = ID_WIDTH'(0);

  // A tag names a real entry only in 1..N; anything else is treated as idle.
  function automatic logic id_in_range(input logic [ID_WIDTH-1:0] id);
    return (id != LP_ZERO) && (id <= LP_N);
  endfunction

  // Circular successor of an entry ID (N wraps back to 1, never to 0).
  function automatic logic [ID_WIDTH-1:0] id_next(input logic [ID_WIDTH-1:0] id);
    return (id == LP_N) ? LP_ONE : (id + LP_ONE);
  endfunction

  // Entry storage; slot 0 exists only so that a raw tag can index directly.
  logic        r_busy      [0:RO_BUFFER_SIZE];
  logic        r_ready     [0:RO_BUFFER_SIZE];
  logic        r_is_branch [0:RO_BUFFER_SIZE];
  logic        r_is_store  [0:RO_BUFFER_SIZE];
  logic [4:0]  r_rd        [0:RO_BUFFER_SIZE];
  logic [31:0] r_pred_pc   [0:RO_BUFFER_SIZE];
  logic [31:0] r_next_pc   [0:RO_BUFFER_SIZE];
  logic [31:0] r_value     [0:RO_BUFFER_SIZE];

  logic [ID_WIDTH-1:0] r_head;
  logic [ID_WIDTH-1:0] r_tail;
  logic [ID_WIDTH-1:0] r_size;

  logic [4:0]          r_rd_out;
  logic [ID_WIDTH-1:0] r_dest_out;
  logic [31:0]         r_value_out;
  logic [ID_WIDTH-1:0] r_store_id_out;
  logic                r_reset_to_rob_bus;
  logic [31:0]         r_target_pc;

  logic                w_commit;
  logic                w_mispredict;
  logic                w_accept;
  logic                w_wb_rss;
  logic                w_wb_lsb;
  logic                w_alloc;
  logic                w_query_ready;
  logic [31:0]         w_query_value;

  // Commit looks only at registered state, so a result written this cycle
  // retires no earlier than the next edge. While the flush pulse is out (and
  // on the flushing edge itself) new allocations and writebacks are dropped.
  assign w_commit     = rdy & r_busy[r_head] & r_ready[r_head];
  assign w_mispredict = w_commit & r_is_branch[r_head] &
                        (r_next_pc[r_head] != r_pred_pc[r_head]);
  assign w_accept     = rdy & ~r_reset_to_rob_bus & ~w_mispredict;
  assign w_wb_rss     = w_accept & id_in_range(dest_from_rss_bus) & r_busy[dest_from_rss_bus];
  assign w_wb_lsb     = w_accept & id_in_range(dest_from_lsb_bus) & r_busy[dest_from_lsb_bus];
  assign w_alloc      = w_accept & alloc_valid_from_issuer & (r_size != LP_N);

  // Operand lookup: live bus results bypass storage, rss bus takes priority.
  always_comb begin
    w_query_ready = 1'b0;
    w_query_value = 32'h0000_0000;
    if (!id_in_range(query_id_from_issuer)) begin
      w_query_ready = 1'b0;
    end else if (dest_from_rss_bus == query_id_from_issuer) begin
      w_query_ready = 1'b1;
      w_query_value = value_from_rss_bus;
    end else if (dest_from_lsb_bus == query_id_from_issuer) begin
      w_query_ready = 1'b1;
      w_query_value = value_from_lsb_bus;
    end else if (r_busy[query_id_from_issuer] && r_ready[query_id_from_issuer]) begin
      w_query_ready = 1'b1;
      w_query_value = r_value[query_id_from_issuer];
    end else begin
      w_query_ready = 1'b0;
    end
  end

  // Entry state, pointers, occupancy and the registered retire/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RO_BUFFER_SIZE; i++) begin
        r_busy[i]  <= 1'b0;
        r_ready[i] <= 1'b0;
      end
      r_head             <= LP_ONE;
      r_tail             <= LP_ONE;
      r_size             <= LP_ZERO;
      r_rd_out           <= 5'd0;
      r_dest_out         <= LP_ZERO;
      r_value_out        <= 32'h0000_0000;
      r_store_id_out     <= LP_ZERO;
      r_reset_to_rob_bus <= 1'b0;
      r_target_pc        <= 32'h0000_0000;
    end else if (!rdy) begin
      r_rd_out           <= 5'd0;
      r_dest_out         <= LP_ZERO;
      r_value_out        <= 32'h0000_0000;
      r_store_id_out     <= LP_ZERO;
      r_reset_to_rob_bus <= 1'b0;
      r_target_pc        <= 32'h0000_0000;
    end else begin
      r_rd_out           <= 5'd0;
      r_dest_out         <= LP_ZERO;
      r_value_out        <= 32'h0000_0000;
      r_store_id_out     <= LP_ZERO;
      r_reset_to_rob_bus <= 1'b0;
      r_target_pc        <= 32'h0000_0000;

      if (w_wb_lsb) begin
        r_ready[dest_from_lsb_bus] <= 1'b1;
        r_value[dest_from_lsb_bus] <= value_from_lsb_bus;
      end
      if (w_wb_rss) begin
        r_ready[dest_from_rss_bus]   <= 1'b1;
        r_value[dest_from_rss_bus]   <= value_from_rss_bus;
        r_next_pc[dest_from_rss_bus] <= next_pc_from_rss_bus;
      end

      if (w_commit) begin
        if (r_is_store[r_head]) begin
          r_store_id_out <= r_head;
        end else begin
          r_rd_out    <= r_rd[r_head];
          r_dest_out  <= r_head;
          r_value_out <= r_value[r_head];
        end
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= id_next(r_head);
      end

      if (w_alloc) begin
        r_busy[r_tail]      <= 1'b1;
        r_ready[r_tail]     <= 1'b0;
        r_is_branch[r_tail] <= is_branch_from_issuer;
        r_is_store[r_tail]  <= is_store_from_issuer;
        r_rd[r_tail]        <= rd_from_issuer;
        r_pred_pc[r_tail]   <= pred_pc_from_issuer;
        r_tail              <= id_next(r_tail);
      end

      case ({w_alloc, w_commit})
        2'b10:   r_size <= r_size + LP_ONE;
        2'b01:   r_size <= r_size - LP_ONE;
        default: r_size <= r_size;
      endcase

      // A mispredicted branch still writes its link value, then empties the buffer.
      if (w_mispredict) begin
        for (int i = 0; i <= RO_BUFFER_SIZE; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
        r_head             <= LP_ONE;
        r_tail             <= LP_ONE;
        r_size             <= LP_ZERO;
        r_reset_to_rob_bus <= 1'b1;
        r_target_pc        <= r_next_pc[r_head];
      end
    end
  end

  assign tail_id_to_issuer     = r_tail;
  assign query_ready_to_issuer = w_query_ready;
  assign query_value_to_issuer = w_query_value;
  assign rd_to_reg_file        = r_rd_out;
  assign dest_to_reg_file      = r_dest_out;
  assign value_to_reg_file     = r_value_out;
  assign store_id_to_lsb       = r_store_id_out;
  assign reset_to_rob_bus      = r_reset_to_rob_bus;
  assign target_pc_to_fetcher  = r_target_pc;
  assign is_ro_buffer_full     = (r_size >= LP_N_M1);

endmodule

// File: tb/tb_ro_buffer.sv
// tb_ro_buffer: directed self-checking bench for the reorder buffer.
// Inputs change 1 time unit after the rising edge; registered outputs are
// therefore observed in the cycle following the edge that produced them.
module tb_ro_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        alloc_valid;
  logic        is_branch;
  logic        is_store;
  logic [4:0]  rd_in;
  logic [31:0] pred_pc;
  logic [4:0]  tail_id;
  logic [4:0]  query_id;
  logic        query_ready;
  logic [31:0] query_value;
  logic [4:0]  rss_dest;
  logic [31:0] rss_value;
  logic [31:0] rss_next_pc;
  logic [4:0]  lsb_dest;
  logic [31:0] lsb_value;
  logic [4:0]  rd_out;
  logic [4:0]  dest_out;
  logic [31:0] value_out;
  logic [4:0]  store_id;
  logic        flush;
  logic [31:0] target_pc;
  logic        full;

  int n_vec;
  int n_miss;

  ro_buffer #(.RO_BUFFER_SIZE(16), .ID_WIDTH(5)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .rdy                     (rdy),
    .alloc_valid_from_issuer (alloc_valid),
    .is_branch_from_issuer   (is_branch),
    .is_store_from_issuer    (is_store),
    .rd_from_issuer          (rd_in),
    .pred_pc_from_issuer     (pred_pc),
    .tail_id_to_issuer       (tail_id),
    .query_id_from_issuer    (query_id),
    .query_ready_to_issuer   (query_ready),
    .query_value_to_issuer   (query_value),
    .dest_from_rss_bus       (rss_dest),
    .value_from_rss_bus      (rss_value),
    .next_pc_from_rss_bus    (rss_next_pc),
    .dest_from_lsb_bus       (lsb_dest),
    .value_from_lsb_bus      (lsb_value),
    .rd_to_reg_file          (rd_out),
    .dest_to_reg_file        (dest_out),
    .value_to_reg_file       (value_out),
    .store_id_to_lsb         (store_id),
    .reset_to_rob_bus        (flush),
    .target_pc_to_fetcher    (target_pc),
    .is_ro_buffer_full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    is_branch   = 1'b0;
    is_store    = 1'b0;
    rd_in       = 5'd0;
    pred_pc     = 32'h0;
    query_id    = 5'd0;
    rss_dest    = 5'd0;
    rss_value   = 32'h0;
    rss_next_pc = 32'h0;
    lsb_dest    = 5'd0;
    lsb_value   = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic br, input logic st, input logic [4:0] rd, input logic [31:0] pc);
    alloc_valid = 1'b1;
    is_branch   = br;
    is_store    = st;
    rd_in       = rd;
    pred_pc     = pc;
    tick();
    alloc_valid = 1'b0;
    is_branch   = 1'b0;
    is_store    = 1'b0;
  endtask

  task automatic rss_wb(input logic [4:0] id, input logic [31:0] val, input logic [31:0] npc);
    rss_dest    = id;
    rss_value   = val;
    rss_next_pc = npc;
    tick();
    rss_dest    = 5'd0;
  endtask

  task automatic check_commit(input string tag, input logic [4:0] rd, input logic [4:0] dst,
                              input logic [31:0] val);
    check_val({tag, "_rd"},    {27'd0, rd_out},   {27'd0, rd});
    check_val({tag, "_dest"},  {27'd0, dest_out}, {27'd0, dst});
    check_val({tag, "_value"}, value_out,         val);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rdy    = 1'b1;
    rst    = 1'b0;
    idle_inputs();

    // 1: reset state, single alloc / writeback / commit
    do_reset();
    check_val("rst_tail",  {27'd0, tail_id}, 32'd1);
    check_val("rst_full",  {31'd0, full},    32'd0);
    check_val("rst_rd",    {27'd0, rd_out},  32'd0);
    check_val("rst_flush", {31'd0, flush},   32'd0);
    check_val("rst_store", {27'd0, store_id}, 32'd0);
    alloc(1'b0, 1'b0, 5'd5, 32'h4);
    check_val("t1_tail", {27'd0, tail_id}, 32'd2);
    rss_wb(5'd1, 32'h2A, 32'h8);
    check_commit("t1_early", 5'd0, 5'd0, 32'h0);
    tick();
    check_commit("t1_commit", 5'd5, 5'd1, 32'h2A);
    tick();
    check_commit("t1_idle", 5'd0, 5'd0, 32'h0);

    // 2: out-of-order completion retires in order
    do_reset();
    alloc(1'b0, 1'b0, 5'd3, 32'h10);
    alloc(1'b0, 1'b0, 5'd4, 32'h14);
    rss_wb(5'd2, 32'h22, 32'h18);
    check_val("t2_no_id2_first", {27'd0, rd_out}, 32'd0);
    rss_wb(5'd1, 32'h11, 32'h14);
    check_val("t2_still_none", {27'd0, rd_out}, 32'd0);
    tick();
    check_commit("t2_id1", 5'd3, 5'd1, 32'h11);
    tick();
    check_commit("t2_id2", 5'd4, 5'd2, 32'h22);
    tick();
    check_commit("t2_idle", 5'd0, 5'd0, 32'h0);

    // 3: fill to pre-full, commit+alloc same edge, tail wrap, overflow ignored
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      alloc(1'b0, 1'b0, 5'(i), 32'h100);
      if (i == 14) check_val("t3_full_at14", {31'd0, full}, 32'd0);
    end
    check_val("t3_full_at15", {31'd0, full},    32'd1);
    check_val("t3_tail16",    {27'd0, tail_id}, 32'd16);
    rss_wb(5'd1, 32'h99, 32'h104);
    alloc(1'b0, 1'b0, 5'd16, 32'h100);
    check_commit("t3_commit", 5'd1, 5'd1, 32'h99);
    check_val("t3_wrap",      {27'd0, tail_id}, 32'd1);
    check_val("t3_full_kept", {31'd0, full},    32'd1);
    alloc(1'b0, 1'b0, 5'd17, 32'h100);
    check_val("t3_tail2",   {27'd0, tail_id}, 32'd2);
    alloc(1'b0, 1'b0, 5'd18, 32'h100);
    check_val("t3_overflow_ignored", {27'd0, tail_id}, 32'd2);

    // 4: mispredicted branch flushes; correct branch does not
    do_reset();
    alloc(1'b1, 1'b0, 5'd1, 32'h104);
    alloc(1'b0, 1'b0, 5'd2, 32'h108);
    rss_wb(5'd1, 32'h104, 32'h200);
    tick();
    check_val("t4_flush",  {31'd0, flush}, 32'd1);
    check_val("t4_target", target_pc,      32'h200);
    check_commit("t4_link", 5'd1, 5'd1, 32'h104);
    check_val("t4_tail",   {27'd0, tail_id}, 32'd1);
    check_val("t4_full",   {31'd0, full},    32'd0);
    alloc(1'b0, 1'b0, 5'd7, 32'h200);
    check_val("t4_flush_drop", {31'd0, flush},    32'd0);
    check_val("t4_target_clr", target_pc,         32'h0);
    check_val("t4_alloc_drop", {27'd0, tail_id},  32'd1);
    alloc(1'b1, 1'b0, 5'd3, 32'h300);
    rss_wb(5'd1, 32'h10, 32'h300);
    tick();
    check_val("t4_good_noflush", {31'd0, flush}, 32'd0);
    check_commit("t4_good", 5'd3, 5'd1, 32'h10);

    // 5: freeze, query bypass, store commit
    do_reset();
    rdy = 1'b0;
    alloc(1'b0, 1'b0, 5'd9, 32'h0);
    check_val("t5_frozen_tail", {27'd0, tail_id}, 32'd1);
    rdy = 1'b1;
    alloc(1'b0, 1'b0, 5'd1, 32'h0);
    alloc(1'b0, 1'b0, 5'd2, 32'h4);
    alloc(1'b0, 1'b1, 5'd0, 32'h8);
    query_id = 5'd2;
    #1;
    check_val("t5_q2_notready", {31'd0, query_ready}, 32'd0);
    query_id  = 5'd3;
    lsb_dest  = 5'd3;
    lsb_value = 32'h77;
    rss_dest  = 5'd1;
    rss_value = 32'hA;
    #1;
    check_val("t5_bypass_ready", {31'd0, query_ready}, 32'd1);
    check_val("t5_bypass_value", query_value,          32'h77);
    query_id = 5'd0;
    #1;
    check_val("t5_q0_ready", {31'd0, query_ready}, 32'd0);
    check_val("t5_q0_value", query_value,          32'h0);
    tick();
    lsb_dest  = 5'd0;
    rss_dest  = 5'd2;
    rss_value = 32'hB;
    query_id  = 5'd3;
    tick();
    rss_dest = 5'd0;
    #1;
    check_commit("t5_id1", 5'd1, 5'd1, 32'hA);
    check_val("t5_q3_stored", query_value, 32'h77);
    tick();
    check_commit("t5_id2", 5'd2, 5'd2, 32'hB);
    tick();
    check_val("t5_store_id", {27'd0, store_id}, 32'd3);
    check_val("t5_store_rd", {27'd0, rd_out},   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
